// File: rtl/can_pkg.sv
// Shared types for the CAN transmit scheduler: frame types, FSM states,
// the stored mailbox record and the bus-priority key builder.
package can_pkg;

  typedef enum logic [1:0] {
    DATA     = 2'd0,
    REMOTE   = 2'd1,
    ERROR    = 2'd2,
    OVERLOAD = 2'd3
  } frame_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_START,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_COMPLETE
  } sched_state_e;

  typedef struct packed {
    logic        format;
    logic        rtr;
    logic [3:0]  dlc;
    logic [28:0] id;
    logic [63:0] data;
  } mailbox_t;

  localparam int PRIO_KEY_W = 31;

  // Arbitration-field order: base, SRR/RTR, IDE, extension. The trailing
  // extended-frame RTR bit does not fit in 31 bits; such ties fall to index.
  function automatic logic [PRIO_KEY_W-1:0] prio_key(input mailbox_t m);
    if (m.format)
      return {m.id[28:18], 1'b1, 1'b1, m.id[17:0]};
    else
      return {m.id[28:18], m.rtr, 1'b0, 18'h0};
  endfunction

  function automatic logic [3:0] clamp_dlc(input logic [3:0] dlc);
    return (dlc > 4'd8) ? 4'd8 : dlc;
  endfunction

endpackage

// File: rtl/can_xmit_sched_if.sv
// Scheduler <-> CAN bit transmitter link: start pulse, frame fields and
// the transmitter/bus-monitor status returned to the scheduler.
interface can_xmit_sched_if;
  logic        startXmit;
  logic        format;
  logic [1:0]  frameType;
  logic [3:0]  datalen;
  logic [28:0] id;
  logic [63:0] xmitdata;
  logic        busy;
  logic        xmit_err;

  modport master (
    output startXmit, format, frameType, datalen, id, xmitdata,
    input  busy, xmit_err
  );

  modport slave (
    input  startXmit, format, frameType, datalen, id, xmitdata,
    output busy, xmit_err
  );
endinterface

// File: rtl/can_prio_select.sv
// Combinational arbiter: among requesting mailboxes, the lowest priority key
// wins; equal keys resolve to the lowest index.
module can_prio_select import can_pkg::*; #(
  parameter  int NUM_MB = 4,
  localparam int IW     = $clog2(NUM_MB)
) (
  input  logic [PRIO_KEY_W-1:0] key [NUM_MB],
  input  logic [NUM_MB-1:0]     req,
  output logic                  valid,
  output logic [IW-1:0]         idx
);
  logic [PRIO_KEY_W-1:0] best;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    best  = '1;
    for (int i = 0; i < NUM_MB; i++) begin
      if (req[i] && (!valid || key[i] < best)) begin
        valid = 1'b1;
        idx   = IW'(i);
        best  = key[i];
      end
    end
  end
endmodule

// File: rtl/can_xmit_sched.sv
// CAN transmit scheduler: mailboxes plus error/overload requests share one
// transmitter. Optional retransmission on bus failure: CAN_SCHED_RETRY_EN.
module can_xmit_sched import can_pkg::*; #(
  parameter  int NUM_MB       = 4,
  parameter  int BUSY_TIMEOUT = 8,
  parameter  int MAX_RETRY    = 8,
  localparam int IW           = $clog2(NUM_MB)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IW-1:0]     wr_idx,
  input  logic              wr_format,
  input  logic              wr_rtr,
  input  logic [3:0]        wr_datalen,
  input  logic [28:0]       wr_id,
  input  logic [63:0]       wr_data,
  input  logic              abort_en,
  input  logic [IW-1:0]     abort_idx,
  input  logic              err_req,
  input  logic              err_type,
  can_xmit_sched_if.master  tx,
  output logic [NUM_MB-1:0] pending,
  output logic [NUM_MB-1:0] done,
  output logic [NUM_MB-1:0] fail,
  output logic              wr_rej,
  output logic              abort_rej,
  output logic              err_done,
  output logic              timeout,
  output logic              sched_busy,
  output logic [IW-1:0]     cur_idx
);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  sched_state_e          state_reg, state_next;
  mailbox_t              mb_reg [NUM_MB];
  logic [PRIO_KEY_W-1:0] key [NUM_MB];
  logic [NUM_MB-1:0]     pending_reg, pending_next;
  logic                  err_flag_reg, err_type_reg, cur_err_reg;
  logic [IW-1:0]         cur_idx_reg;
  logic [TW-1:0]         cnt_reg;
  logic                  wr_rej_reg, abort_rej_reg;
  logic                  format_reg;
  frame_type_e           frame_type_reg;
  logic [3:0]            datalen_reg;
  logic [28:0]           id_reg;
  logic [63:0]           data_reg;
  logic                  sel_valid;
  logic [IW-1:0]         sel_idx;
  logic                  inflight_mb;
  logic [IW-1:0]         inflight_idx;
  logic                  wr_ok, abort_hit, abort_busy;
  logic                  frame_failed, retry_exhausted, mb_clear, bus_expired;
  logic [NUM_MB-1:0]     cur_onehot;

  generate
    for (genvar gi = 0; gi < NUM_MB; gi++) begin : g_key
      assign key[gi] = prio_key(mb_reg[gi]);
    end
  endgenerate

  can_prio_select #(.NUM_MB(NUM_MB)) u_sel (
    .key   (key),
    .req   (pending_reg),
    .valid (sel_valid),
    .idx   (sel_idx)
  );

  // During SELECT the winner is already committed, so it counts as in flight.
  always_comb begin
    inflight_mb  = 1'b0;
    inflight_idx = cur_idx_reg;
    if (state_reg == ST_SELECT) begin
      inflight_mb  = !err_flag_reg && sel_valid;
      inflight_idx = sel_idx;
    end else if (state_reg != ST_IDLE) begin
      inflight_mb  = !cur_err_reg;
    end
  end

  assign wr_ok       = wr_en && !pending_reg[wr_idx];
  assign abort_hit   = abort_en && pending_reg[abort_idx];
  assign abort_busy  = abort_hit && inflight_mb && (inflight_idx == abort_idx);
  assign cur_onehot  = NUM_MB'(1) << cur_idx_reg;
  assign bus_expired = (cnt_reg == TW'(BUSY_TIMEOUT - 1)) && !tx.busy;

`ifdef CAN_SCHED_RETRY_EN
  logic       fail_seen_reg;
  logic [3:0] retry_reg [NUM_MB];

  assign frame_failed    = fail_seen_reg;
  assign retry_exhausted = (retry_reg[cur_idx_reg] >= 4'(MAX_RETRY));
  assign fail = (state_reg == ST_COMPLETE && !cur_err_reg && frame_failed && retry_exhausted)
                ? cur_onehot : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      fail_seen_reg <= 1'b0;
      for (int i = 0; i < NUM_MB; i++) retry_reg[i] <= '0;
    end else begin
      if (state_reg == ST_START)
        fail_seen_reg <= 1'b0;
      else if (state_reg == ST_WAIT_DONE && tx.xmit_err)
        fail_seen_reg <= 1'b1;
      if (wr_ok)
        retry_reg[wr_idx] <= '0;
      if (state_reg == ST_COMPLETE && !cur_err_reg && frame_failed && !retry_exhausted)
        retry_reg[cur_idx_reg] <= retry_reg[cur_idx_reg] + 4'd1;
    end
  end
`else
  logic unused_xmit_err;
  assign unused_xmit_err = tx.xmit_err;
  assign frame_failed    = 1'b0;
  assign retry_exhausted = 1'b0;
  assign fail            = '0;
`endif

  assign mb_clear = !cur_err_reg && (!frame_failed || retry_exhausted);

  // Abort is applied before the write, and the write sees the old flag.
  always_comb begin
    pending_next = pending_reg;
    if (abort_hit && !abort_busy)
      pending_next[abort_idx] = 1'b0;
    if (state_reg == ST_COMPLETE && mb_clear)
      pending_next[cur_idx_reg] = 1'b0;
    if (wr_ok)
      pending_next[wr_idx] = 1'b1;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:      if (err_flag_reg || |pending_reg) state_next = ST_SELECT;
      ST_SELECT:    state_next = (err_flag_reg || sel_valid) ? ST_START : ST_IDLE;
      ST_START:     state_next = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (tx.busy)         state_next = ST_WAIT_DONE;
        else if (bus_expired) state_next = ST_IDLE;
      end
      ST_WAIT_DONE: if (!tx.busy) state_next = ST_COMPLETE;
      ST_COMPLETE:  state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      pending_reg    <= '0;
      err_flag_reg   <= 1'b0;
      err_type_reg   <= 1'b0;
      cur_err_reg    <= 1'b0;
      cur_idx_reg    <= '0;
      cnt_reg        <= '0;
      wr_rej_reg     <= 1'b0;
      abort_rej_reg  <= 1'b0;
      format_reg     <= 1'b0;
      frame_type_reg <= DATA;
      datalen_reg    <= '0;
      id_reg         <= '0;
      data_reg       <= '0;
      for (int i = 0; i < NUM_MB; i++) mb_reg[i] <= '0;
    end else begin
      state_reg     <= state_next;
      pending_reg   <= pending_next;
      wr_rej_reg    <= wr_en && pending_reg[wr_idx];
      abort_rej_reg <= abort_busy;
      if (wr_ok)
        mb_reg[wr_idx] <= '{format: wr_format, rtr: wr_rtr, dlc: clamp_dlc(wr_datalen),
                            id: wr_id, data: wr_data};
      if (state_reg == ST_COMPLETE && cur_err_reg)
        err_flag_reg <= 1'b0;
      else if (err_req && !err_flag_reg) begin
        err_flag_reg <= 1'b1;
        err_type_reg <= err_type;
      end
      if (state_reg == ST_SELECT) begin
        cur_err_reg <= err_flag_reg;
        cur_idx_reg <= sel_idx;
        if (err_flag_reg) begin
          format_reg     <= 1'b0;
          frame_type_reg <= err_type_reg ? OVERLOAD : ERROR;
          datalen_reg    <= '0;
          id_reg         <= '0;
          data_reg       <= '0;
        end else if (sel_valid) begin
          format_reg     <= mb_reg[sel_idx].format;
          frame_type_reg <= mb_reg[sel_idx].rtr ? REMOTE : DATA;
          datalen_reg    <= mb_reg[sel_idx].dlc;
          id_reg         <= mb_reg[sel_idx].id;
          data_reg       <= mb_reg[sel_idx].data;
        end
      end
      if (state_reg == ST_START)
        cnt_reg <= '0;
      else if (state_reg == ST_WAIT_BUSY)
        cnt_reg <= cnt_reg + TW'(1);
    end
  end

  assign tx.startXmit = (state_reg == ST_START);
  assign tx.format    = format_reg;
  assign tx.frameType = frame_type_reg;
  assign tx.datalen   = datalen_reg;
  assign tx.id        = id_reg;
  assign tx.xmitdata  = data_reg;

  assign pending    = pending_reg;
  assign wr_rej     = wr_rej_reg;
  assign abort_rej  = abort_rej_reg;
  assign timeout    = (state_reg == ST_WAIT_BUSY) && bus_expired;
  assign sched_busy = (state_reg != ST_IDLE);
  assign cur_idx    = cur_idx_reg;
  assign done       = (state_reg == ST_COMPLETE && !cur_err_reg && !frame_failed)
                      ? cur_onehot : '0;
  assign err_done   = (state_reg == ST_COMPLETE) && cur_err_reg && !frame_failed;
endmodule
